// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Contents:
//   state_e          loader FSM state encodings
//   LANE_FIRST/LAST  byte-lane positions inside a little-endian 32-bit word
//   csum_update      running XOR checksum step
//   is_stream_state  1 in the states that consume bytes from the host link
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

    localparam logic [1:0] LANE_FIRST = 2'd0;
    localparam logic [1:0] LANE_LAST  = 2'd3;

    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

    function automatic logic is_stream_state(input state_e st);
        logic res;
        case (st)
            ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM: res = 1'b1;
            default:                                res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Host byte link plus IMEM write port of the boot loader.
//   in_valid/in_data/in_ready   byte stream handshake (host -> loader)
//   imem_we/imem_addr/imem_wdata one-cycle word write strobe (loader -> IMEM)
// master = host/memory side, slave = loader side.
interface imem_loader_if #(parameter int ADDR_W = 8);

    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes into 32-bit little-endian words.
//   clk, reset   clock, asynchronous active-low reset
//   clear        drop any partial word and restart at lane 0
//   push         one byte accepted this cycle
//   byte_in      the accepted byte
//   word         {byte_in, b2, b1, b0}; meaningful while word_valid
//   word_valid   push of the 4th byte of a word (combinational)
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  lane_r;
    // Only the first three bytes are stored; the fourth is taken straight from byte_in.
    logic [23:0] shift_r;

    // Lane counter and shift register: newest byte enters at the top.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_r  <= LANE_FIRST;
            shift_r <= 24'd0;
        end else if (clear) begin
            lane_r  <= LANE_FIRST;
            shift_r <= 24'd0;
        end else if (push) begin
            lane_r  <= lane_r + 2'd1;
            shift_r <= {byte_in, shift_r[23:8]};
        end else begin
            lane_r  <= lane_r;
            shift_r <= shift_r;
        end
    end

    // Word assembly and completion flag.
    always_comb begin
        word       = {byte_in, shift_r};
        word_valid = push & (lane_r == LANE_LAST);
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time IMEM writer: parses LEN_LO, LEN_HI, 4*N data bytes, CSUM from the
// byte link, writes N little-endian words to consecutive word addresses from 0,
// verifies the XOR checksum and releases the core on success.
//   clk, reset    clock, asynchronous active-low reset
//   start         re-arm from DONE/ERR (ignored elsewhere)
//   bus           byte stream + IMEM write port (slave modport)
//   words_loaded  words written in the current load
//   core_hold     1 keeps the core in reset (0 only in DONE)
//   done, error   load complete and good / overflow or checksum mismatch
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    imem_loader_if.slave    bus,
    output logic [ADDR_W:0] words_loaded,
    output logic            core_hold,
    output logic            done,
    output logic            error
);

    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

    state_e            state_r, state_next_s;
    logic              accept_s;
    logic [15:0]       len_s;
    logic [7:0]        len_lo_r;
    logic [15:0]       rem_r;
    logic [7:0]        csum_r;
    logic              packer_clear_s;
    logic              data_push_s;
    logic [31:0]       word_s;
    logic              word_valid_s;
    logic              in_ready_r;
    logic              imem_we_r;
    logic [ADDR_W-1:0] imem_addr_r;
    logic [31:0]       imem_wdata_r;
    logic [ADDR_W:0]   words_loaded_r;
    logic              core_hold_r;
    logic              done_r;
    logic              error_r;

    assign accept_s       = bus.in_valid & in_ready_r;
    assign len_s          = {bus.in_data, len_lo_r};
    assign packer_clear_s = (state_r == ST_IDLE);
    assign data_push_s    = accept_s & (state_r == ST_DATA);

    imem_loader_byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (packer_clear_s),
        .push       (data_push_s),
        .byte_in    (bus.in_data),
        .word       (word_s),
        .word_valid (word_valid_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: state_next_s = ST_LEN_LO;
            ST_LEN_LO: begin
                if (accept_s) state_next_s = ST_LEN_HI;
                else          state_next_s = state_r;
            end
            ST_LEN_HI: begin
                if (!accept_s)                   state_next_s = state_r;
                else if ({1'b0, len_s} > MAX_WORDS) state_next_s = ST_ERR;
                else if (len_s == 16'd0)         state_next_s = ST_CSUM;
                else                             state_next_s = ST_DATA;
            end
            ST_DATA: begin
                if (accept_s && (rem_r == 16'd1)) state_next_s = ST_CSUM;
                else                              state_next_s = state_r;
            end
            ST_CSUM: begin
                if (!accept_s)                 state_next_s = state_r;
                else if (bus.in_data == csum_r) state_next_s = ST_DONE;
                else                           state_next_s = ST_ERR;
            end
            ST_DONE, ST_ERR: begin
                if (start) state_next_s = ST_IDLE;
                else       state_next_s = state_r;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Frame bookkeeping: length capture, remaining-byte counter, XOR accumulator.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_lo_r <= 8'd0;
            rem_r    <= 16'd0;
            csum_r   <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    len_lo_r <= 8'd0;
                    rem_r    <= 16'd0;
                    csum_r   <= 8'd0;
                end
                ST_LEN_LO: begin
                    if (accept_s) len_lo_r <= bus.in_data;
                    else          len_lo_r <= len_lo_r;
                end
                ST_LEN_HI: begin
                    // Byte count of the payload; only reached for N <= 2**ADDR_W.
                    if (accept_s) rem_r <= {len_s[13:0], 2'b00};
                    else          rem_r <= rem_r;
                end
                ST_DATA: begin
                    if (accept_s) begin
                        rem_r  <= rem_r - 16'd1;
                        csum_r <= csum_update(csum_r, bus.in_data);
                    end else begin
                        rem_r  <= rem_r;
                        csum_r <= csum_r;
                    end
                end
                default: begin
                    len_lo_r <= len_lo_r;
                    rem_r    <= rem_r;
                    csum_r   <= csum_r;
                end
            endcase
        end
    end

    // IMEM write port and word counter; address is the pre-increment count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            imem_we_r      <= 1'b0;
            imem_addr_r    <= '0;
            imem_wdata_r   <= 32'd0;
            words_loaded_r <= '0;
        end else begin
            imem_we_r <= word_valid_s;
            if (word_valid_s) begin
                imem_addr_r    <= words_loaded_r[ADDR_W-1:0];
                imem_wdata_r   <= word_s;
                words_loaded_r <= words_loaded_r + 1'b1;
            end else if (state_r == ST_IDLE) begin
                imem_addr_r    <= imem_addr_r;
                imem_wdata_r   <= imem_wdata_r;
                words_loaded_r <= '0;
            end else begin
                imem_addr_r    <= imem_addr_r;
                imem_wdata_r   <= imem_wdata_r;
                words_loaded_r <= words_loaded_r;
            end
        end
    end

    // Status outputs registered from the next state so they track the state register exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready_r  <= 1'b0;
            core_hold_r <= 1'b1;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            in_ready_r  <= is_stream_state(state_next_s);
            core_hold_r <= (state_next_s != ST_DONE);
            done_r      <= (state_next_s == ST_DONE);
            error_r     <= (state_next_s == ST_ERR);
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.imem_we    = imem_we_r;
    assign bus.imem_addr  = imem_addr_r;
    assign bus.imem_wdata = imem_wdata_r;
    assign words_loaded   = words_loaded_r;
    assign core_hold      = core_hold_r;
    assign done           = done_r;
    assign error          = error_r;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int ADDR_W = 8;
    localparam int NWORDS = 1 << ADDR_W;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [ADDR_W:0] words_loaded;
    logic            core_hold, done, error;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .words_loaded (words_loaded),
        .core_hold    (core_hold),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int due_cyc = -10;
    int data_cnt = 0;
    bit mon_en = 1'b0;
    int wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] frame_words [0:NWORDS-1];

    typedef struct {
        int n; int flip; int gap; bit spec_words;
        bit exp_done; bit exp_err; int exp_words;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: strobe must appear exactly one cycle after each 4th data byte.
    always @(negedge clk) begin
        if (mon_en) begin
            check("imem_we_timing", {63'd0, bus.imem_we}, {63'd0, (cyc == due_cyc)});
            if (bus.imem_we === 1'b1) begin
                wr_addr_q.push_back(int'(bus.imem_addr));
                wr_data_q.push_back(bus.imem_wdata);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input bit is_data, input int gap_pct);
        int waited;
        bit ok;
        ok = 1'b0;
        waited = 0;
        for (int g = 0; g < 8; g++) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!ok && waited < 100) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                ok = 1'b1;
                if (is_data) begin
                    data_cnt++;
                    if (data_cnt % 4 == 0) due_cyc = cyc + 1;
                end
            end
            @(posedge clk); #1;
            waited++;
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL handshake_timeout: byte %0h got no in_ready within 100 cycles", b);
        end
    endtask

    task automatic run_frame(input int n, input int flip, input int gap_pct);
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'd0;
        data_cnt = 0;
        send_byte(n[7:0], 1'b0, gap_pct);
        send_byte(n[15:8], 1'b0, gap_pct);
        if (n <= NWORDS) begin
            for (int i = 0; i < n; i++) begin
                for (int k = 0; k < 4; k++) begin
                    b  = frame_words[i][8*k +: 8];
                    cs = cs ^ b;
                    send_byte(b, 1'b1, gap_pct);
                end
            end
            send_byte(cs ^ flip[7:0], 1'b0, gap_pct);
        end
    endtask

    // Reference outcome: overflow or bad checksum -> ERR, else DONE; words written = N unless overflow.
    task automatic check_outcome(input string tag, input int n, input int flip);
        bit exp_err;
        int exp_w;
        exp_err = (n > NWORDS) || (flip != 0);
        exp_w   = (n > NWORDS) ? 0 : n;
        @(negedge clk);
        check({tag, ".done"}, {63'd0, done}, {63'd0, !exp_err});
        check({tag, ".error"}, {63'd0, error}, {63'd0, exp_err});
        check({tag, ".core_hold"}, {63'd0, core_hold}, {63'd0, exp_err});
        check({tag, ".words_loaded"}, 64'(words_loaded), 64'(exp_w));
        check({tag, ".nwrites"}, 64'(wr_addr_q.size()), 64'(exp_w));
        for (int i = 0; i < wr_addr_q.size() && i < exp_w; i++) begin
            check({tag, ".addr"}, 64'(wr_addr_q[i]), 64'(i));
            check({tag, ".wdata"}, 64'(wr_data_q[i]), 64'(frame_words[i]));
        end
        if (exp_w > 0) begin
            check({tag, ".addr_hold"}, 64'(bus.imem_addr), 64'(exp_w - 1));
            check({tag, ".wdata_hold"}, 64'(bus.imem_wdata), 64'(frame_words[exp_w - 1]));
        end
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    // Re-arm from DONE/ERR while a stray byte is offered: start wins, byte not taken.
    task automatic restart_with_stray_byte(input string tag);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        start = 1'b1;
        @(negedge clk);
        check({tag, ".ready_in_final"}, {63'd0, bus.in_ready}, 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check({tag, ".rearm_done"}, {63'd0, done}, 64'd0);
        check({tag, ".rearm_error"}, {63'd0, error}, 64'd0);
        check({tag, ".rearm_hold"}, {63'd0, core_hold}, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".in_ready"}, {63'd0, bus.in_ready}, 64'd0);
        check({tag, ".imem_we"}, {63'd0, bus.imem_we}, 64'd0);
        check({tag, ".imem_addr"}, 64'(bus.imem_addr), 64'd0);
        check({tag, ".imem_wdata"}, 64'(bus.imem_wdata), 64'd0);
        check({tag, ".words_loaded"}, 64'(words_loaded), 64'd0);
        check({tag, ".core_hold"}, {63'd0, core_hold}, 64'd1);
        check({tag, ".done"}, {63'd0, done}, 64'd0);
        check({tag, ".error"}, {63'd0, error}, 64'd0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;

        vecs[0] = '{2,     0,    0,  1'b1, 1'b1, 1'b0, 2};
        vecs[1] = '{2,     1,    0,  1'b1, 1'b0, 1'b1, 2};
        vecs[2] = '{2,     0,    0,  1'b1, 1'b1, 1'b0, 2};
        vecs[3] = '{0,     0,    0,  1'b0, 1'b1, 1'b0, 0};
        vecs[4] = '{257,   0,    0,  1'b0, 1'b0, 1'b1, 0};
        vecs[5] = '{4,     0,    50, 1'b0, 1'b1, 1'b0, 4};
        vecs[6] = '{256,   0,    0,  1'b0, 1'b1, 1'b0, 256};
        vecs[7] = '{3,     8'h80, 30, 1'b0, 1'b0, 1'b1, 3};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1;
        reset  = 1'b1;
        mon_en = 1'b1;

        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < NWORDS; i++) frame_words[i] = $urandom;
            if (vecs[v].spec_words) begin
                frame_words[0] = 32'h00500013;
                frame_words[1] = 32'h00A00093;
            end
            run_frame(vecs[v].n, vecs[v].flip, vecs[v].gap);
            check_outcome($sformatf("vec%0d", v), vecs[v].n, vecs[v].flip);
            check($sformatf("vec%0d.tbl_done", v), {63'd0, done}, {63'd0, vecs[v].exp_done});
            check($sformatf("vec%0d.tbl_error", v), {63'd0, error}, {63'd0, vecs[v].exp_err});
            check($sformatf("vec%0d.tbl_words", v), 64'(words_loaded), 64'(vecs[v].exp_words));
            restart_with_stray_byte($sformatf("vec%0d", v));
        end

        for (int r = 0; r < 10; r++) begin
            int n;
            int flip;
            n    = int'($urandom_range(12, 1));
            flip = ($urandom_range(3) == 0) ? int'($urandom_range(255, 1)) : 0;
            for (int i = 0; i < n; i++) frame_words[i] = $urandom;
            run_frame(n, flip, 50);
            check_outcome($sformatf("rnd%0d", r), n, flip);
            restart_with_stray_byte($sformatf("rnd%0d", r));
        end

        // Reset in the middle of the second word of an N=4 frame.
        for (int i = 0; i < 4; i++) frame_words[i] = $urandom;
        data_cnt = 0;
        send_byte(8'd4, 1'b0, 0);
        send_byte(8'd0, 1'b0, 0);
        for (int k = 0; k < 6; k++) send_byte(frame_words[k / 4][8*(k % 4) +: 8], 1'b1, 0);
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("midreset");
        check("midreset.nwrites", 64'(wr_addr_q.size()), 64'd1);
        if (wr_addr_q.size() > 0) begin
            check("midreset.addr0", 64'(wr_addr_q[0]), 64'd0);
            check("midreset.data0", 64'(wr_data_q[0]), 64'(frame_words[0]));
        end
        wr_addr_q.delete();
        wr_data_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) frame_words[i] = $urandom;
        run_frame(2, 0, 0);
        check_outcome("after_reset", 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
